// File: rtl/isqrt_pipe_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined isqrt among
// NUM_REQ requesters and routes each result back through a tag delay line.
module isqrt_pipe_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ISQRT_LAT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [32*NUM_REQ-1:0]          req_x,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             rsp_vld,
  output logic [15:0]                    rsp_y,
  output logic                           isqrt_x_vld,
  output logic [31:0]                    isqrt_x,
  input  logic                           isqrt_y_vld,
  input  logic [15:0]                    isqrt_y,
  output logic [$clog2(ISQRT_LAT+1)-1:0] inflight,
  output logic                           err_orphan
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(ISQRT_LAT + 1);

  logic [IW-1:0] rr_ptr;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [SW-1:0] scan;
  logic [31:0]   x_mux;

  logic                 tag_vld [ISQRT_LAT];
  logic [IW-1:0]        tag_idx [ISQRT_LAT];
  logic                 last_vld;
  logic [IW-1:0]        last_idx;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + SW'(k);
      if (scan >= SW'(NUM_REQ)) scan = scan - SW'(NUM_REQ);
      if (req_vld[scan[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IW-1:0];
      end
    end
    if (rst) gnt_any = 1'b0;
  end

  always_comb begin
    x_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && gnt_idx == IW'(i)) x_mux = req_x[32*i +: 32];
    end
  end

  assign req_rdy     = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign isqrt_x_vld = gnt_any;
  assign isqrt_x     = x_mux;

  assign last_vld = tag_vld[ISQRT_LAT-1];
  assign last_idx = tag_idx[ISQRT_LAT-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      rsp_vld    <= '0;
      rsp_y      <= '0;
      inflight   <= '0;
      err_orphan <= 1'b0;
      for (int s = 0; s < ISQRT_LAT; s++) tag_vld[s] <= 1'b0;
    end else begin
      if (gnt_any) rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);

      tag_vld[0] <= gnt_any;
      for (int s = 1; s < ISQRT_LAT; s++) tag_vld[s] <= tag_vld[s-1];

      rsp_vld <= '0;
      if (isqrt_y_vld && last_vld) begin
        rsp_vld <= NUM_REQ'(1) << last_idx;
        rsp_y   <= isqrt_y;
      end
      // A result without a tag, or a tag without a result, is dropped and flagged.
      if (isqrt_y_vld != last_vld) err_orphan <= 1'b1;

      if (gnt_any && !last_vld)      inflight <= inflight + CW'(1);
      else if (!gnt_any && last_vld) inflight <= inflight - CW'(1);
    end
  end

  // NOTE: the tag indices are a plain data pipe qualified by tag_vld, so they
  // are left out of reset.
  always_ff @(posedge clk) begin
    tag_idx[0] <= gnt_idx;
    for (int s = 1; s < ISQRT_LAT; s++) tag_idx[s] <= tag_idx[s-1];
  end

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Bench for isqrt_pipe_arbiter: behavioural isqrt pipe, issue-level reference
// model with an expected-response queue, directed and random stimulus.
module tb_isqrt_pipe_arbiter;
  localparam int N   = 4;
  localparam int LAT = 16;
  localparam int CW  = $clog2(LAT + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld, req_rdy, rsp_vld;
  logic [32*N-1:0] req_x;
  logic [15:0]     rsp_y, isqrt_y;
  logic            isqrt_x_vld, isqrt_y_vld;
  logic [31:0]     isqrt_x;
  logic [CW-1:0]   inflight;
  logic            err_orphan;
  logic            force_y_vld;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int max_inflight = 0;

  isqrt_pipe_arbiter #(.NUM_REQ(N), .ISQRT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y), .inflight(inflight),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bit-serial square root used by the stand-in isqrt block.
  function automatic logic [15:0] hw_sqrt(input logic [31:0] x);
    logic [15:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (32'(t) * 32'(t) <= x) r = t;
    end
    return r;
  endfunction

  // Independent reference: floating-point root, then exact integer correction.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
    longint xl, r;
    real    xr;
    xl = longint'({32'd0, x});
    xr = real'(xl);
    r  = longint'($floor($sqrt(xr)));
    while (r * r > xl) r--;
    while ((r + 1) * (r + 1) <= xl) r++;
    return 16'(r);
  endfunction

  // Stand-in pipelined isqrt with latency LAT, reset by the same rst.
  logic [LAT-1:0] iq_vld;
  logic [15:0]    iq_y [LAT];
  always @(posedge clk) begin
    if (rst) iq_vld <= '0;
    else begin
      iq_vld[0] <= isqrt_x_vld;
      for (int s = 1; s < LAT; s++) iq_vld[s] <= iq_vld[s-1];
    end
    iq_y[0] <= hw_sqrt(isqrt_x);
    for (int s = 1; s < LAT; s++) iq_y[s] <= iq_y[s-1];
  end
  assign isqrt_y_vld = iq_vld[LAT-1] | force_y_vld;
  assign isqrt_y     = iq_y[LAT-1];

  typedef struct { int idx; logic [15:0] y; int due; } exp_t;
  typedef struct { int at; logic [N-1:0] vld; logic [15:0] y; } rsp_t;
  exp_t exp_q[$];
  rsp_t log_q[$];
  int        ptr_m;
  logic [15:0] last_y;
  bit        err_m;

  // Reference model, evaluated mid-cycle on every falling edge.
  always @(negedge clk) begin : model
    logic [N-1:0] exp_vld, exp_rdy;
    logic [31:0]  exp_x;
    int           g;
    bit           due_next;
    cyc++;
    if (rst) begin
      check("rst_rdy", 32'(req_rdy), 32'd0);
      exp_q.delete();
      ptr_m  = 0;
      last_y = '0;
      err_m  = 1'b0;
    end else begin
      exp_vld = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_vld = N'(1) << exp_q[0].idx;
        last_y  = exp_q[0].y;
        void'(exp_q.pop_front());
      end
      if (|rsp_vld) log_q.push_back('{cyc, rsp_vld, rsp_y});
      check("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
      check("rsp_y", 32'(rsp_y), 32'(last_y));
      check("inflight", 32'(inflight), 32'(exp_q.size()));
      check("err_orphan", 32'(err_orphan), 32'(err_m));
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);

      due_next = exp_q.size() > 0 && exp_q[0].due == cyc + 1;
      if (isqrt_y_vld != due_next) begin
        err_m = 1'b1;
        if (due_next) void'(exp_q.pop_front());
      end

      g = -1;
      for (int k = N - 1; k >= 0; k--) begin
        if (req_vld[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      exp_x   = (g >= 0) ? req_x[32*g +: 32] : 32'd0;
      check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      check("isqrt_x_vld", 32'(isqrt_x_vld), (g >= 0) ? 32'd1 : 32'd0);
      check("isqrt_x", isqrt_x, exp_x);
      if (g >= 0) begin
        exp_q.push_back('{g, ref_sqrt(exp_x), cyc + LAT + 1});
        ptr_m = (g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    tick();
    rst = 1'b1;
    req_vld = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  logic [31:0] lane_x [N];
  logic [31:0] bnd [3];
  int t0;

  initial begin
    rst = 1'b1;
    force_y_vld = 1'b0;
    req_vld = '1;
    req_x = '0;
    for (int i = 0; i < N; i++) req_x[32*i +: 32] = $urandom;

    // Reset held with every requester asking: no grants, clean state after.
    repeat (3) tick();
    rst = 1'b0;
    req_vld = '0;
    @(negedge clk);
    #1;
    check("post_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("post_rst_inflight", 32'(inflight), 32'd0);
    check("post_rst_err", 32'(err_orphan), 32'd0);

    // Single op from requester 2.
    tick();
    log_q.delete();
    t0 = cyc + 1;
    req_vld = 4'b0100;
    req_x[64 +: 32] = 32'd144;
    tick();
    req_vld = '0;
    repeat (LAT + 4) tick();
    check("single_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      check("single_lat", 32'(log_q[0].at - t0), 32'(LAT + 1));
      check("single_vld", 32'(log_q[0].vld), 32'h4);
      check("single_y", 32'(log_q[0].y), 32'd12);
    end

    // Round-robin from a fresh pointer with all four requesting.
    do_reset(2);
    log_q.delete();
    t0 = cyc + 1;
    for (int i = 0; i < N; i++) begin
      lane_x[i] = $urandom;
      req_x[32*i +: 32] = lane_x[i];
    end
    req_vld = '1;
    repeat (8) tick();
    req_vld = '0;
    repeat (LAT + 4) tick();
    check("rr_count", 32'(log_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      check("rr_at", 32'(log_q[k].at - t0), 32'(LAT + 1 + k));
      check("rr_vld", 32'(log_q[k].vld), 32'(N'(1) << (k % N)));
      check("rr_y", 32'(log_q[k].y), 32'(ref_sqrt(lane_x[k % N])));
    end

    // Requester 1 streams perfect squares back-to-back.
    log_q.delete();
    max_inflight = 0;
    t0 = cyc + 1;
    for (int n = 0; n < 40; n++) begin
      req_vld = 4'b0010;
      req_x[32 +: 32] = 32'(n * n);
      tick();
    end
    req_vld = '0;
    repeat (LAT + 4) tick();
    check("b2b_count", 32'(log_q.size()), 32'd40);
    for (int k = 0; k < log_q.size() && k < 40; k++) begin
      check("b2b_at", 32'(log_q[k].at - t0), 32'(LAT + 1 + k));
      check("b2b_y", 32'(log_q[k].y), 32'(k));
    end
    check("b2b_inflight_max", 32'(max_inflight), 32'(LAT));

    // Boundary arguments through requester 3.
    bnd[0] = 32'd0;
    bnd[1] = 32'hFFFF_FFFF;
    bnd[2] = 32'd3;
    log_q.delete();
    for (int k = 0; k < 3; k++) begin
      req_vld = 4'b1000;
      req_x[96 +: 32] = bnd[k];
      tick();
    end
    req_vld = '0;
    repeat (LAT + 4) tick();
    check("bnd_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() >= 3) begin
      check("bnd_zero", 32'(log_q[0].y), 32'd0);
      check("bnd_max", 32'(log_q[1].y), 32'hFFFF);
      check("bnd_three", 32'(log_q[2].y), 32'd1);
    end

    // Random traffic, checked cycle by cycle by the model.
    for (int c = 0; c < 300; c++) begin
      req_vld = N'($urandom);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       req_x[32*i +: 32] = 32'hFFFF_FFFF;
          1:       req_x[32*i +: 32] = 32'($urandom_range(0, 20));
          default: req_x[32*i +: 32] = $urandom;
        endcase
      end
      tick();
    end
    req_vld = '0;

    // Orphan result with nothing in flight.
    repeat (LAT + 4) tick();
    log_q.delete();
    force_y_vld = 1'b1;
    tick();
    force_y_vld = 1'b0;
    repeat (2) tick();
    check("orphan_err", 32'(err_orphan), 32'd1);
    check("orphan_no_rsp", 32'(log_q.size()), 32'd0);

    // Reset with five operations pending.
    for (int k = 0; k < 5; k++) begin
      req_vld = 4'b0001;
      req_x[31:0] = $urandom;
      tick();
    end
    req_vld = '0;
    repeat (3) tick();
    do_reset(2);
    log_q.delete();
    repeat (LAT + 6) tick();
    check("midrst_no_rsp", 32'(log_q.size()), 32'd0);
    check("midrst_inflight", 32'(inflight), 32'd0);
    check("midrst_err", 32'(err_orphan), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
